// File: rtl/ram_sequencer.sv
// rtl/ram_sequencer.sv - fill/scan sequencer in front of a single-port synchronous RAM (optional RAM_SEQ_CHECK_EN scan checker)
module ram_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 4,
  parameter int RD_LAT       = 1,
  parameter int DWELL_CYCLES = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start_fill,
  input  logic              start_scan,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_data,
  input  logic              man_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_q,
  output logic              scan_valid
`ifdef RAM_SEQ_CHECK_EN
  ,
  output logic              err_flag,
  output logic [ADDR_W:0]   err_count
`endif
);

  // RD_LAT is at most 3, so two bits cover the read-latency counter.
  localparam int LAT_W   = 2;
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(RD_LAT);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SCAN_RD,
    S_SCAN_HOLD,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   seed_q;
  logic [LAT_W-1:0]    lat_q;
  logic [DWELL_W-1:0]  dwell_q;

  logic [DATA_W-1:0]   pattern;
  logic                wren_raw;
  logic                load_fill;
  logic                load_scan;
  logic                addr_inc;
  logic                capture;
  logic                lat_end;
  logic                dwell_end;
  logic                at_last;

  // The fill pattern and the scan check both use seed plus the low address bits.
  assign pattern   = seed_q + DATA_W'(addr_q);
  assign lat_end   = (lat_q == LAT_LAST);
  assign dwell_end = (dwell_q == DWELL_LAST);
  assign at_last   = (addr_q == LAST_ADDR);

  // Write enable is gated by reset directly so it drops the instant resetn falls.
  assign ram_wren = resetn & wren_raw;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, RAM port mux and datapath control strobes.
  always_comb begin
    state_d     = state_q;
    ram_address = addr_q;
    ram_data    = '0;
    wren_raw    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    load_fill   = 1'b0;
    load_scan   = 1'b0;
    addr_inc    = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ram_address = man_addr;
        ram_data    = man_data;
        wren_raw    = man_wren;
        busy        = 1'b0;
        if (start_fill) begin
          load_fill = 1'b1;
          state_d   = S_FILL;
        end else if (start_scan) begin
          load_scan = 1'b1;
          state_d   = S_SCAN_RD;
        end
      end
      S_FILL: begin
        ram_data = pattern;
        wren_raw = 1'b1;
        addr_inc = 1'b1;
        if (at_last) begin
          state_d = S_DONE;
        end
      end
      S_SCAN_RD: begin
        if (lat_end) begin
          capture = 1'b1;
          state_d = S_SCAN_HOLD;
        end
      end
      S_SCAN_HOLD: begin
        if (dwell_end) begin
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            addr_inc = 1'b1;
            state_d  = S_SCAN_RD;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address, seed and the read-latency / dwell counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      seed_q  <= '0;
      lat_q   <= '0;
      dwell_q <= '0;
    end else begin
      if (load_fill) begin
        seed_q <= fill_value;
        addr_q <= '0;
      end else if (load_scan) begin
        addr_q <= '0;
      end else if (addr_inc) begin
        addr_q <= addr_q + 1'b1;
      end

      if (state_q == S_SCAN_RD && !lat_end) begin
        lat_q <= lat_q + 1'b1;
      end else begin
        lat_q <= '0;
      end

      if (state_q == S_SCAN_HOLD && !dwell_end) begin
        dwell_q <= dwell_q + 1'b1;
      end else begin
        dwell_q <= '0;
      end
    end
  end

  // Scan capture registers; scan_valid marks the cycle after each capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scan_addr  <= '0;
      scan_q     <= '0;
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= capture;
      if (capture) begin
        scan_q    <= ram_q;
        scan_addr <= addr_q;
      end
    end
  end

`ifdef RAM_SEQ_CHECK_EN
  // Compare each captured word against the last fill pattern; cleared at scan start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (load_scan) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (capture && (ram_q != pattern)) begin
      err_flag <= 1'b1;
      if (err_count != {(ADDR_W+1){1'b1}}) begin
        err_count <= err_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_sequencer.sv
// tb/tb_ram_sequencer.sv - randomized self-checking bench for ram_sequencer against a behavioural RAM and content model
module tb_ram_sequencer;

  logic       clock;
  logic       resetn;
  logic       start_fill;
  logic       start_scan;
  logic [3:0] fill_value;
  logic [4:0] man_addr;
  logic [3:0] man_data;
  logic       man_wren;
  logic [3:0] ram_q;
  logic [4:0] ram_address;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic [4:0] scan_addr;
  logic [3:0] scan_q;
  logic       scan_valid;
`ifdef RAM_SEQ_CHECK_EN
  logic       err_flag;
  logic [5:0] err_count;
`endif

  int vec_cnt = 0;
  int mis_cnt = 0;

  logic [3:0] mem [32];
  logic [3:0] model_mem [32];
  logic [3:0] cap_q [32];
  logic [3:0] last_seed;

  ram_sequencer #(
    .ADDR_W(5), .DATA_W(4), .RD_LAT(1), .DWELL_CYCLES(4)
  ) dut (
    .clock(clock), .resetn(resetn),
    .start_fill(start_fill), .start_scan(start_scan), .fill_value(fill_value),
    .man_addr(man_addr), .man_data(man_data), .man_wren(man_wren),
    .ram_q(ram_q), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done),
    .scan_addr(scan_addr), .scan_q(scan_q), .scan_valid(scan_valid)
`ifdef RAM_SEQ_CHECK_EN
    , .err_flag(err_flag), .err_count(err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 32x4 synchronous RAM, one-edge read latency.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_fill(input logic [3:0] val, input bit scan_too);
    @(negedge clock);
    start_fill = 1'b1;
    fill_value = val;
    start_scan = scan_too;
    @(negedge clock);
    start_fill = 1'b0;
    fill_value = 4'($urandom);
    for (int i = 0; i < 32; i++) begin
      check("fill_wren", ram_wren, 1);
      check("fill_addr", ram_address, i);
      check("fill_data", ram_data, (int'(val) + i) % 16);
      check("fill_busy", busy, 1);
      model_mem[i] = 4'((int'(val) + i) % 16);
      if (i == 20) start_scan = 1'b0;
      @(negedge clock);
    end
    check("fill_done", done, 1);
    check("fill_done_wren", ram_wren, 0);
    @(negedge clock);
    check("fill_done_once", done, 0);
    check("fill_idle_busy", busy, 0);
    repeat (3) @(negedge clock);
    check("no_queued_scan", busy, 0);
    last_seed = val;
  endtask

  task automatic man_write(input logic [4:0] a, input logic [3:0] d);
    @(negedge clock);
    man_addr = a;
    man_data = d;
    man_wren = 1'b1;
    #1;
    check("man_addr", ram_address, a);
    check("man_data", ram_data, d);
    check("man_wren", ram_wren, 1);
    @(negedge clock);
    man_wren = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic run_scan();
    int c;
    int nv;
    int prev;
    int ndone;
    int exp_err;
    exp_err = 0;
    for (int i = 0; i < 32; i++)
      if (model_mem[i] != 4'((int'(last_seed) + i) % 16)) exp_err++;
    nv = 0;
    prev = 0;
    ndone = 0;
    @(negedge clock);
    start_scan = 1'b1;
    @(negedge clock);
    start_scan = 1'b0;
    c = 1;
    while (c <= 400 && ndone == 0) begin
      if (c == 100) check("scan_busy", busy, 1);
      if (scan_valid) begin
        if (nv < 32) begin
          check("scan_addr", scan_addr, nv);
          check("scan_q", scan_q, model_mem[nv]);
          cap_q[nv] = scan_q;
        end
        if (nv == 0) check("first_valid_cycle", c, 3);
        else check("valid_spacing", c - prev, 6);
        prev = c;
        nv++;
      end
      if (done) begin
        ndone++;
        check("scan_done_cycle", c, 193);
      end
      @(negedge clock);
      c++;
    end
    check("scan_finished", ndone, 1);
    check("scan_valid_count", nv, 32);
    check("scan_idle_busy", busy, 0);
    repeat (2) @(negedge clock);
    check("scan_q_hold", scan_q, model_mem[31]);
    check("scan_addr_hold", scan_addr, 31);
`ifdef RAM_SEQ_CHECK_EN
    check("err_count", err_count, exp_err);
    check("err_flag", err_flag, exp_err != 0);
`endif
  endtask

  initial begin
    logic [3:0] r;
    resetn     = 1'b0;
    start_fill = 1'b0;
    start_scan = 1'b0;
    fill_value = 4'h0;
    man_addr   = 5'h11;
    man_data   = 4'h6;
    man_wren   = 1'b1;
    last_seed  = 4'h0;
    for (int i = 0; i < 32; i++) model_mem[i] = 4'h0;
    #2;
    check("rst_wren", ram_wren, 0);
    check("rst_addr", ram_address, 5'h11);
    check("rst_data", ram_data, 4'h6);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", scan_valid, 0);
    check("rst_scan_addr", scan_addr, 0);
    check("rst_scan_q", scan_q, 0);
    @(negedge clock);
    man_wren = 1'b0;
    @(negedge clock);
    resetn = 1'b1;

    // Reset in the middle of a fill.
    r = 4'($urandom);
    @(negedge clock);
    start_fill = 1'b1;
    fill_value = r;
    @(negedge clock);
    start_fill = 1'b0;
    repeat (10) @(negedge clock);
    check("midfill_addr", ram_address, 10);
    check("midfill_wren", ram_wren, 1);
    resetn = 1'b0;
    #1;
    check("midrst_wren", ram_wren, 0);
    check("midrst_busy", busy, 0);
    check("midrst_scan_q", scan_q, 0);
    for (int i = 0; i < 10; i++) model_mem[i] = 4'((int'(r) + i) % 16);
    last_seed = 4'h0;
    @(negedge clock);
    resetn   = 1'b1;
    man_addr = 5'h03;
    man_wren = 1'b0;
    #1;
    check("post_rst_pass", ram_address, 5'h03);
    check("post_rst_busy", busy, 0);

    // Fill with both commands high, then manual overwrite, then scan.
    run_fill(4'h3, 1'b1);
    man_write(5'h1F, 4'h9);
    run_scan();
    check("cap_addr7", cap_q[7], 4'hA);
    check("cap_addr31", cap_q[31], 4'h9);
    check("cap_addr13", cap_q[13], 4'h0);

    // Randomized rounds.
    for (int k = 0; k < 2; k++) begin
      run_fill(4'($urandom_range(0, 15)), 1'($urandom));
      for (int j = 0; j < 3; j++) man_write(5'($urandom), 4'($urandom));
      run_scan();
    end

`ifdef RAM_SEQ_CHECK_EN
    run_fill(4'h0, 1'b0);
    man_write(5'h04, 4'hF);
    run_scan();
    check("chk_err_one", err_count, 1);
    run_fill(4'h0, 1'b0);
    run_scan();
    check("chk_err_zero", err_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
